// File: rtl/processor_pkg.sv
// Shared types and constants for the processor call unit and its return-address stack.
package processor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SHADOW  = 2'd2
    } call_state_t;

    localparam int RAS_DEPTH_DEFAULT = 16;
    localparam int RAS_PTR_W         = $clog2(RAS_DEPTH_DEFAULT) + 1;

    // Pointer must reach DEPTH itself, so one bit wider than the index.
    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/call_stack_ram.sv
// Register-array LIFO backing the return-address stack; push wins if both are asserted.
module call_stack_ram
    import processor_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEFAULT,
    parameter int WIDTH = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int SP_W  = ras_ptr_w(DEPTH);
    localparam int IDX_W = $clog2(DEPTH);

    logic [SP_W-1:0]  sp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx = sp[IDX_W-1:0];
    assign rd_idx = IDX_W'(sp - SP_W'(1));
    assign full   = (sp == SP_W'(DEPTH));
    assign empty  = (sp == '0);
    assign top    = mem[rd_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            sp          <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/processor_call_unit.sv
// Fetch redirect producer for call/jump/ret with a hardware return-address stack.
// Optional CALL_UNIT_TRAP_EN: stack overflow/underflow redirect to TRAP_ADDR.
module processor_call_unit
    import processor_pkg::*;
#(
    parameter int ADDR_SIZE   = 18,
    parameter int WORD_SIZE   = 18,
    parameter int STACK_DEPTH = RAS_DEPTH_DEFAULT,
    parameter logic [WORD_SIZE-1:0] TRAP_ADDR = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 no_operation_in,
    input  logic [ADDR_SIZE-1:0] ip_in,
    input  logic                 is_call,
    input  logic                 is_jump,
    input  logic                 is_ret,
    input  logic [WORD_SIZE-1:0] target,
    input  logic                 fetch_stall,
    output logic                 call_performed,
    output logic [WORD_SIZE-1:0] ip_to_call,
    output logic                 return_performed,
    output logic [WORD_SIZE-1:0] ip_to_return,
    output logic                 busy,
    output logic                 stack_overflow,
    output logic                 stack_underflow
);

`ifdef CALL_UNIT_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    call_state_t          state;
    logic                 accept, do_ret, do_call, do_jump;
    logic                 ras_full, ras_empty;
    logic [WORD_SIZE-1:0] ras_top;
    logic [ADDR_SIZE-1:0] ip_next;
    logic [WORD_SIZE-1:0] ret_addr;

    // Only IDLE accepts; ret outranks call, call outranks jump.
    assign accept   = (state == IDLE) && !no_operation_in;
    assign do_ret   = accept && is_ret;
    assign do_call  = accept && !is_ret && is_call;
    assign do_jump  = accept && !is_ret && !is_call && is_jump;
    assign ip_next  = ip_in + ADDR_SIZE'(1);
    assign ret_addr = WORD_SIZE'(ip_next);
    assign busy     = (state != IDLE);

    call_stack_ram #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (WORD_SIZE)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (do_call),
        .pop       (do_ret),
        .push_data (ret_addr),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            call_performed   <= 1'b0;
            ip_to_call       <= '0;
            return_performed <= 1'b0;
            ip_to_return     <= '0;
            stack_overflow   <= 1'b0;
            stack_underflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_ret) begin
                        if (!ras_empty) begin
                            return_performed <= 1'b1;
                            ip_to_return     <= ras_top;
                            state            <= PENDING;
                        end else begin
                            stack_underflow <= 1'b1;
                            if (TRAP_EN) begin
                                call_performed <= 1'b1;
                                ip_to_call     <= TRAP_ADDR;
                                state          <= PENDING;
                            end
                        end
                    end else if (do_call || do_jump) begin
                        call_performed <= 1'b1;
                        ip_to_call     <= target;
                        state          <= PENDING;
                        if (do_call && ras_full) begin
                            stack_overflow <= 1'b1;
                            if (TRAP_EN) ip_to_call <= TRAP_ADDR;
                        end
                    end
                end
                PENDING: begin
                    // Fetch takes the redirect on the first unstalled cycle.
                    if (!fetch_stall) begin
                        call_performed   <= 1'b0;
                        return_performed <= 1'b0;
                        state            <= SHADOW;
                    end
                end
                SHADOW: begin
                    // First real slot here is the wrong-path fetch; drop it.
                    if (!no_operation_in) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_processor_call_unit.sv
// Directed self-checking bench for processor_call_unit.
module tb_processor_call_unit;

`ifdef CALL_UNIT_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [17:0] TRAP = 18'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        no_operation_in;
    logic [17:0] ip_in;
    logic        is_call, is_jump, is_ret;
    logic [17:0] target;
    logic        fetch_stall;
    logic        call_performed;
    logic [17:0] ip_to_call;
    logic        return_performed;
    logic [17:0] ip_to_return;
    logic        busy;
    logic        stack_overflow;
    logic        stack_underflow;

    int tests = 0;
    int fails = 0;

    processor_call_unit #(
        .ADDR_SIZE   (18),
        .WORD_SIZE   (18),
        .STACK_DEPTH (16),
        .TRAP_ADDR   (TRAP)
    ) u_dut (
        .clock            (clock),
        .reset            (reset),
        .no_operation_in  (no_operation_in),
        .ip_in            (ip_in),
        .is_call          (is_call),
        .is_jump          (is_jump),
        .is_ret           (is_ret),
        .target           (target),
        .fetch_stall      (fetch_stall),
        .call_performed   (call_performed),
        .ip_to_call       (ip_to_call),
        .return_performed (return_performed),
        .ip_to_return     (ip_to_return),
        .busy             (busy),
        .stack_overflow   (stack_overflow),
        .stack_underflow  (stack_underflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slot(input logic nop, input logic [17:0] ip, input logic c, input logic j,
                        input logic r, input logic [17:0] tgt);
        no_operation_in = nop; ip_in = ip; is_call = c; is_jump = j; is_ret = r; target = tgt;
    endtask

    task automatic bubble();
        slot(1'b1, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0);
    endtask

    // Let fetch take the redirect, then burn the shadow slot with a real (no-opcode) instruction.
    task automatic finish_redirect();
        fetch_stall = 1'b0;
        bubble();
        tick();
        slot(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0);
        tick();
        bubble();
    endtask

    task automatic do_call(input string tag, input logic [17:0] ip, input logic [17:0] tgt,
                           input logic [17:0] exp_tgt);
        slot(1'b0, ip, 1'b1, 1'b0, 1'b0, tgt);
        tick();
        chk({tag, ".cp"}, call_performed, 1);
        chk({tag, ".tgt"}, ip_to_call, exp_tgt);
        finish_redirect();
    endtask

    task automatic do_ret(input string tag, input logic [17:0] exp_ra);
        slot(1'b0, 18'h0, 1'b0, 1'b0, 1'b1, 18'h0);
        tick();
        chk({tag, ".rp"}, return_performed, 1);
        chk({tag, ".ra"}, ip_to_return, exp_ra);
        finish_redirect();
    endtask

    initial begin
        reset = 1'b1;
        fetch_stall = 1'b0;
        bubble();
        tick(); tick();
        reset = 1'b0;
        chk("rst.cp", call_performed, 0);
        chk("rst.rp", return_performed, 0);
        chk("rst.ipc", ip_to_call, 0);
        chk("rst.ipr", ip_to_return, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ovf", stack_overflow, 0);
        chk("rst.unf", stack_underflow, 0);
        chk("rst.sp", u_dut.u_ras.sp, 0);

        // Single call: one-cycle pulse, then wrong-path jump in shadow discarded
        slot(1'b0, 18'h00010, 1'b1, 1'b0, 1'b0, 18'h00100);
        tick();
        chk("c1.cp", call_performed, 1);
        chk("c1.tgt", ip_to_call, 18'h00100);
        chk("c1.busy", busy, 1);
        chk("c1.sp", u_dut.u_ras.sp, 1);
        bubble();
        tick();
        chk("c1.drop", call_performed, 0);
        chk("c1.shadow", busy, 1);
        slot(1'b0, 18'h00100, 1'b0, 1'b1, 1'b0, 18'h00200);
        tick();
        chk("c1.squash.cp", call_performed, 0);
        chk("c1.squash.busy", busy, 0);
        bubble();

        // Return to 0x11; bubbles must not end shadow
        slot(1'b0, 18'h00100, 1'b0, 1'b0, 1'b1, 18'h0);
        tick();
        chk("r1.rp", return_performed, 1);
        chk("r1.ra", ip_to_return, 18'h00011);
        chk("r1.sp", u_dut.u_ras.sp, 0);
        bubble();
        tick();
        chk("r1.drop", return_performed, 0);
        tick();
        chk("r1.bubble.busy", busy, 1);
        slot(1'b0, 18'h0, 1'b0, 1'b0, 1'b0, 18'h0);
        tick();
        chk("r1.idle", busy, 0);
        bubble();

        // Stall holds the redirect
        fetch_stall = 1'b1;
        slot(1'b0, 18'h00020, 1'b1, 1'b0, 1'b0, 18'h00300);
        tick();
        bubble();
        for (int i = 0; i < 3; i++) begin
            chk("stall.cp", call_performed, 1);
            chk("stall.tgt", ip_to_call, 18'h00300);
            if (i < 2) tick();
        end
        fetch_stall = 1'b0;
        tick();
        chk("stall.drop", call_performed, 0);
        finish_redirect();
        chk("stall.idle", busy, 0);
        do_ret("r2", 18'h00021);

        // Overflow: 17 nested calls, then 16 LIFO returns
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 16; i++)
            do_call("nest", 18'h01000 + 18'(i), 18'h02000 + 18'(i), 18'h02000 + 18'(i));
        chk("nest.sp16", u_dut.u_ras.sp, 16);
        chk("nest.noovf", stack_overflow, 0);
        do_call("ovf", 18'h01100, 18'h03000, TRAP_EN ? TRAP : 18'h03000);
        chk("ovf.flag", stack_overflow, 1);
        chk("ovf.sp", u_dut.u_ras.sp, 16);
        for (int i = 0; i < 16; i++)
            do_ret("lifo", 18'h01010 - 18'(i));
        chk("lifo.sp0", u_dut.u_ras.sp, 0);
        chk("ovf.sticky", stack_overflow, 1);

        // Underflow
        slot(1'b0, 18'h00500, 1'b0, 1'b0, 1'b1, 18'h0);
        tick();
        chk("unf.flag", stack_underflow, 1);
        chk("unf.rp", return_performed, 0);
        chk("unf.sp", u_dut.u_ras.sp, 0);
        chk("unf.cp", call_performed, TRAP_EN ? 1 : 0);
        if (TRAP_EN) begin
            chk("unf.trap", ip_to_call, TRAP);
            finish_redirect();
        end
        chk("unf.busy", busy, 0);
        bubble();

        // Priority ret > call > jump on a fresh stack
        reset = 1'b1; tick(); reset = 1'b0;
        slot(1'b0, 18'h00040, 1'b1, 1'b1, 1'b0, 18'h00440);
        tick();
        chk("prio.sp", u_dut.u_ras.sp, 1);
        chk("prio.tgt", ip_to_call, 18'h00440);
        finish_redirect();

        // Address wrap at top of the space
        reset = 1'b1; tick(); reset = 1'b0;
        do_call("wrap", 18'h3FFFF, 18'h00005, 18'h00005);
        do_ret("wrap.ret", 18'h00000);

        // Reset while PENDING (stalled)
        fetch_stall = 1'b1;
        slot(1'b0, 18'h00050, 1'b1, 1'b0, 1'b0, 18'h00600);
        tick();
        chk("rp.cp", call_performed, 1);
        bubble();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fetch_stall = 1'b0;
        chk("rp.cp0", call_performed, 0);
        chk("rp.ipc0", ip_to_call, 0);
        chk("rp.busy0", busy, 0);
        chk("rp.sp0", u_dut.u_ras.sp, 0);
        chk("rp.unf0", stack_underflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/processor_call_unit.md
Name: processor_call_unit

Overview:
- Redirect producer for the fetch stage: consumes decoded call/jump/return instructions from decode.
- Drives call_performed/ip_to_call and return_performed/ip_to_return to fetch.
- Owns a hardware return-address stack (RAS): push on call, pop on return.
- Squashes the single wrong-path instruction that fetch has already issued.

Parameters:
ADDR_SIZE, 18, instruction address width
WORD_SIZE, 18, redirect target width (matches fetch ip)
STACK_DEPTH, 16, RAS entries; power of two, >=2
TRAP_ADDR, 0, trap vector (used only with optional feature)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
no_operation_in  in  1  current decode slot is a bubble; ignore all opcode inputs
ip_in  in  ADDR_SIZE  address of current instruction
is_call  in  1  call to target
is_jump  in  1  unconditional jump to target
is_ret  in  1  return
target  in  WORD_SIZE  call/jump destination
fetch_stall  in  1  same signal fetch receives as its stall; redirect is consumed only when 0
call_performed  out  1  redirect to ip_to_call (calls and jumps)
ip_to_call  out  WORD_SIZE  call/jump target
return_performed  out  1  redirect to ip_to_return
ip_to_return  out  WORD_SIZE  popped return address
busy  out  1  redirect pending or shadow active
stack_overflow  out  1  sticky
stack_underflow  out  1  sticky

Behaviour:
- Reset: all outputs 0, sp=0, state IDLE, RAS contents don't-care.
- At most one of is_call/is_jump/is_ret is high. Priority if violated: ret > call > jump.
- FSM has three states: IDLE, PENDING, SHADOW.
- IDLE, accepted instruction (no_operation_in=0):
  - call: push ip_in+1, truncated mod 2^ADDR_SIZE and zero-extended to WORD_SIZE; register target into ip_to_call; call_performed=1 next cycle; go PENDING.
  - jump: same as call, no push.
  - ret: pop into ip_to_return; return_performed=1 next cycle; go PENDING.
  - Other opcodes are ignored.
- Latency: redirect pulse appears exactly 1 cycle after the instruction is accepted.
- PENDING:
  - Redirect outputs are held stable while fetch_stall=1.
  - On the first cycle with fetch_stall=0, fetch consumes the redirect; outputs drop next cycle; go SHADOW.
  - The slot at decode during PENDING is wrong path and is ignored.
- SHADOW:
  - The next slot with no_operation_in=0 is discarded (the wrong-path instruction fetched before redirect).
  - Then go IDLE.
  - Slots with no_operation_in=1 do not end SHADOW.
- busy=1 in PENDING and SHADOW.
- Stack pointer: sp counts 0..STACK_DEPTH.
  - Full: sp==STACK_DEPTH.
  - Empty: sp==0.
- Call when full: redirect still performed, no push, sp unchanged, stack_overflow set.
- Ret when empty: no redirect, sp unchanged, stack_underflow set, stay IDLE.
- Sticky flags clear only on reset.
- Reset mid-PENDING: redirect outputs drop the following cycle; sp=0.

Optional Feature:
- Macro: CALL_UNIT_TRAP_EN.
- Defined: overflow and underflow each force a call_performed redirect to TRAP_ADDR instead of the behaviour above. On overflow this replaces the target; on underflow it replaces the ignore. The sticky flag is still set.
- Not defined: behaviour as above; TRAP_ADDR unused.

Decomposition:
- Shared package processor_pkg holds:
  - FSM state encoding (IDLE, PENDING, SHADOW);
  - RAS pointer-width constant, $clog2(STACK_DEPTH)+1.
- One sub-module: call_stack_ram. It holds the STACK_DEPTH x WORD_SIZE register-array LIFO with push/pop, full/empty and top output.
- The FSM and redirect registers remain in processor_call_unit.

Test Plan:
- Call with ip_in=0x00010, target=0x00100, fetch_stall=0 -> call_performed=1 with ip_to_call=0x00100 next cycle for one cycle; following non-bubble slot discarded.
- Call at 0x00010 then ret -> return_performed=1 with ip_to_return=0x00011; sp returns to 0.
- Call accepted, fetch_stall=1 for 3 cycles -> call_performed and ip_to_call held 3 cycles, drop 1 cycle after stall clears.
- 17 nested calls with STACK_DEPTH=16 -> 17th still redirects, stack_overflow=1, then 16 rets return the correct addresses in LIFO order.
- Ret on empty stack -> no redirect, stack_underflow=1; with CALL_UNIT_TRAP_EN, call_performed=1 to TRAP_ADDR.
- Call at ip_in=0x3FFFF -> pushed return address 0x00000 (wrap); reset asserted in PENDING -> all outputs 0 next cycle.
